shift_register_universal: RTL and testbench
===========================================

Name: shift_register_universal

Overview:
- Parametrised, multi-mode successor to the 6-bit right shift register.
- Supports right and left shifts and rotates, synchronous parallel load, and a counted burst of N shifts with busy/done handshake.
- Feeds serial converters and lab sequencers; provides true and complementary parallel outputs plus a serial output tap.

Parameters:
- WIDTH, 6, register width in bits (>=2).
- COUNT_WIDTH, 3, width of the shiftCount burst-length input.

Ports:
- clockpulse  input  1  sole clock; all state updates on rising edge.
- clear  input  1  reset, synchronous, active-high.
- mode  input  2  burst operation: 00 shift right, 01 shift left, 10 rotate right, 11 rotate left.
- serialInputMsb  input  1  bit entering at out[WIDTH-1] on shift right.
- serialInputLsb  input  1  bit entering at out[0] on shift left.
- enablePreset  input  1  synchronous parallel load request.
- preset  input  WIDTH  parallel load value.
- start  input  1  burst request, sampled only in IDLE.
- shiftCount  input  COUNT_WIDTH  number of shifts in the burst (0..2^COUNT_WIDTH-1).
- out  output  WIDTH  register contents.
- notout  output  WIDTH  always ~out.
- serialOutput  output  1  bit discarded or wrapped by the most recent shift.
- busy  output  1  high while the burst is in SHIFT state.
- done  output  1  one-cycle pulse when a burst completes.

Behaviour:
- Reset (clear=1 at edge): out=0, notout=all ones, serialOutput=0, busy=0, done=0, state=IDLE, internal counter=0. Reset has highest priority, including mid-burst; an aborted burst never produces done.
- Priority at each edge: clear > enablePreset > burst activity > hold.
- enablePreset=1: out<=preset at that edge.
  - In SHIFT or DONE, it aborts: state->IDLE, busy=0 next cycle, no done pulse.
  - Loading does not change serialOutput.
  - A start asserted together with enablePreset is ignored.
- States:
  - IDLE: register holds; busy=0, done=0.
  - SHIFT: busy=1.
  - DONE: done=1 for exactly one cycle, busy=0.
- IDLE + start (no preset, no clear) at edge k:
  - Latch mode and shiftCount; remaining<=shiftCount.
  - If shiftCount=0: state->DONE. No shift occurs; done is high during cycle k+1.
  - Else: state->SHIFT; busy is high from cycle k+1.
- SHIFT: one shift per edge using the latched mode. Edges k+1..k+N perform shifts 1..N.
  - remaining decrements each shift; at the edge performing shift N, state->DONE.
  - Result: busy high for exactly N cycles; done high in cycle k+N+1; return to IDLE at edge k+N+1.
- Per-mode shift at each shift edge:
  - Shift right: out<={serialInputMsb, out[WIDTH-1:1]}; serialOutput<=old out[0].
  - Shift left: out<={out[WIDTH-2:0], serialInputLsb}; serialOutput<=old out[WIDTH-1].
  - Rotate right: out<={out[0], out[WIDTH-1:1]}; serialOutput<=old out[0].
  - Rotate left: out<={out[WIDTH-2:0], out[WIDTH-1]}; serialOutput<=old out[WIDTH-1].
- Serial inputs are sampled live at each shift edge; they are not latched at start.
- mode and shiftCount changes during a burst are ignored. start while busy or in DONE is ignored; start is accepted again in the cycle after DONE.
- N > WIDTH is legal: shifts fill entirely with serial input; rotates wrap modulo WIDTH.
- notout is purely combinational from out; there is never a cycle where notout != ~out.

Decomposition:
- Shared package contents:
  - Mode encodings: MODE_SHR=2'b00, MODE_SHL=2'b01, MODE_ROR=2'b10, MODE_ROL=2'b11.
  - State encodings: IDLE, SHIFT, DONE.
- Natural sub-module: shift_stage, one per bit. It holds the bit flop plus a next-state mux selecting hold / load / left neighbour / right neighbour, with synchronous clear. It is instantiated WIDTH times by generate.
- The top level holds the FSM, counter and serialOutput.

Test Plan (WIDTH=6, COUNT_WIDTH=3):
- Reset: clear=1 for 1 cycle -> out=000000, notout=111111, busy=0, done=0, serialOutput=0.
- Load 101101; start, mode=00, N=2, serialInputMsb=1 -> busy high 2 cycles, then out=111011, serialOutput=0, done pulse 1 cycle.
- Load 100110; start, mode=11, N=3 -> out=110100, notout=001011, serialOutput=0, done once.
- Load 000001; start, mode=01, N=5, serialInputLsb=0; assert enablePreset with preset=010101 after 2 shifts -> out=010101, busy=0 next cycle, done never asserts.
- start with N=0 on out=101010 -> done high the following cycle, busy never high, out=101010. Also: start pulsed while busy -> ignored, burst length unchanged.
- clear mid-burst (mode=10, N=7, after 3 shifts) -> next cycle out=000000, IDLE, busy=0, no done; new start then runs a normal burst.

Source files
------------

// File: rtl/shift_register_universal_pkg.sv
// Shared encodings for the universal shift register: burst modes, FSM states
// and the per-bit next-value select used by each shift stage.
package shift_register_universal_pkg;

   typedef enum logic [1:0] {
      MODE_SHR = 2'b00,
      MODE_SHL = 2'b01,
      MODE_ROR = 2'b10,
      MODE_ROL = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_e;

   // SEL_UPPER takes bit i+1 (right shift), SEL_LOWER takes bit i-1 (left shift)
   typedef enum logic [1:0] {
      SEL_HOLD  = 2'b00,
      SEL_LOAD  = 2'b01,
      SEL_UPPER = 2'b10,
      SEL_LOWER = 2'b11
   } stage_sel_e;

   function automatic logic is_right(input mode_e m);
      return (m == MODE_SHR) || (m == MODE_ROR);
   endfunction

endpackage

// File: rtl/shift_register_universal_shift_stage.sv
// One register bit: flop with synchronous clear and a hold/load/neighbour mux.
module shift_stage
   import shift_register_universal_pkg::*;
(
   input  logic       clockpulse,
   input  logic       clear,
   input  stage_sel_e sel,
   input  logic       preset_bit,
   input  logic       upper_bit,
   input  logic       lower_bit,
   output logic       q
);

   logic d;

   // NOTE: every path assigns d, so no latch is inferred.
   always_comb begin
      case (sel)
         SEL_LOAD:  d = preset_bit;
         SEL_UPPER: d = upper_bit;
         SEL_LOWER: d = lower_bit;
         default:   d = q;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clockpulse) begin
      if (clear) q <= 1'b0;
      else       q <= d;
   end

endmodule

// File: rtl/shift_register_universal.sv
// Multi-mode shift register: parallel load, shifts/rotates in counted bursts
// with busy/done handshake. Bit storage lives in WIDTH shift_stage instances.
module shift_register_universal
   import shift_register_universal_pkg::*;
#(
   parameter int WIDTH       = 6,
   parameter int COUNT_WIDTH = 3
) (
   input  logic                   clockpulse,
   input  logic                   clear,
   input  logic [1:0]             mode,
   input  logic                   serialInputMsb,
   input  logic                   serialInputLsb,
   input  logic                   enablePreset,
   input  logic [WIDTH-1:0]       preset,
   input  logic                   start,
   input  logic [COUNT_WIDTH-1:0] shiftCount,
   output logic [WIDTH-1:0]       out,
   output logic [WIDTH-1:0]       notout,
   output logic                   serialOutput,
   output logic                   busy,
   output logic                   done
);

   state_e                 state_q, state_d;
   mode_e                  mode_q;
   logic [COUNT_WIDTH-1:0] remaining;
   stage_sel_e             sel;
   logic                   shifting;
   logic                   accept_start;

   assign shifting     = !enablePreset && (state_q == SHIFT);
   assign accept_start = !enablePreset && (state_q == IDLE) && start;

   always_comb begin
      sel = SEL_HOLD;
      if (enablePreset)  sel = SEL_LOAD;
      else if (shifting) sel = is_right(mode_q) ? SEL_UPPER : SEL_LOWER;
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_stage
      logic upper_bit;
      logic lower_bit;

      // End bits wrap for rotates and take the serial input for shifts
      if (i == WIDTH - 1) begin : g_msb
         assign upper_bit = (mode_q == MODE_ROR) ? out[0] : serialInputMsb;
      end else begin : g_upper
         assign upper_bit = out[i+1];
      end

      if (i == 0) begin : g_lsb
         assign lower_bit = (mode_q == MODE_ROL) ? out[WIDTH-1] : serialInputLsb;
      end else begin : g_lower
         assign lower_bit = out[i-1];
      end

      shift_stage u_stage (
         .clockpulse (clockpulse),
         .clear      (clear),
         .sel        (sel),
         .preset_bit (preset[i]),
         .upper_bit  (upper_bit),
         .lower_bit  (lower_bit),
         .q          (out[i])
      );
   end

   always_comb begin
      state_d = state_q;
      if (enablePreset) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (start) state_d = (shiftCount == '0) ? DONE : SHIFT;
            SHIFT:   if (remaining == COUNT_WIDTH'(1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clockpulse) begin
      if (clear) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clockpulse) begin
      if (clear) begin
         remaining    <= '0;
         mode_q       <= MODE_SHR;
         serialOutput <= 1'b0;
      end else if (accept_start) begin
         remaining <= shiftCount;
         mode_q    <= mode_e'(mode);
      end else if (shifting) begin
         remaining    <= remaining - COUNT_WIDTH'(1);
         serialOutput <= is_right(mode_q) ? out[0] : out[WIDTH-1];
      end
   end

   assign notout = ~out;
   assign busy   = (state_q == SHIFT);
   assign done   = (state_q == DONE);

endmodule

// File: tb/tb_shift_register_universal.sv
// Randomized and directed bench for shift_register_universal against a
// cycle-level behavioural model built from the shift/rotate arithmetic.
module tb_shift_register_universal;

   localparam int W  = 6;
   localparam int CW = 3;
   localparam logic [W-1:0] MASK = '1;

   logic          clockpulse = 1'b0;
   logic          clear = 1'b0;
   logic [1:0]    mode = '0;
   logic          serialInputMsb = 1'b0;
   logic          serialInputLsb = 1'b0;
   logic          enablePreset = 1'b0;
   logic [W-1:0]  preset = '0;
   logic          start = 1'b0;
   logic [CW-1:0] shiftCount = '0;
   logic [W-1:0]  out, notout;
   logic          serialOutput, busy, done;

   shift_register_universal #(.WIDTH(W), .COUNT_WIDTH(CW)) dut (
      .clockpulse     (clockpulse),
      .clear          (clear),
      .mode           (mode),
      .serialInputMsb (serialInputMsb),
      .serialInputLsb (serialInputLsb),
      .enablePreset   (enablePreset),
      .preset         (preset),
      .start          (start),
      .shiftCount     (shiftCount),
      .out            (out),
      .notout         (notout),
      .serialOutput   (serialOutput),
      .busy           (busy),
      .done           (done)
   );

   always #5 clockpulse = ~clockpulse;

   int vectors = 0;
   int miscompares = 0;
   int busy_n = 0;
   int done_n = 0;

   // Reference model: register value, last discarded bit, shifts left to do
   int unsigned m_reg = 0;
   int unsigned m_so = 0;
   int          m_left = 0;
   bit          m_done = 1'b0;
   int unsigned m_mode = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   function automatic void model_edge();
      int unsigned msb_bit, lsb_bit;
      msb_bit = (m_reg >> (W - 1)) & 1;
      lsb_bit = m_reg & 1;
      if (clear) begin
         m_reg = 0; m_so = 0; m_left = 0; m_done = 0;
      end else if (enablePreset) begin
         m_reg = preset; m_left = 0; m_done = 0;
      end else if (m_left > 0) begin
         case (m_mode)
            0: begin m_reg = (m_reg >> 1) | (serialInputMsb << (W - 1)); m_so = lsb_bit; end
            1: begin m_reg = ((m_reg << 1) | serialInputLsb) & MASK;     m_so = msb_bit; end
            2: begin m_reg = (m_reg >> 1) | (lsb_bit << (W - 1));        m_so = lsb_bit; end
            default: begin m_reg = ((m_reg << 1) | msb_bit) & MASK;     m_so = msb_bit; end
         endcase
         m_left--;
         if (m_left == 0) m_done = 1;
      end else if (m_done) begin
         m_done = 0;
      end else if (start) begin
         m_mode = mode;
         m_left = shiftCount;
         if (m_left == 0) m_done = 1;
      end
   endfunction

   task automatic tick();
      model_edge();
      @(posedge clockpulse);
      #1;
      check("out", 32'(out), m_reg);
      check("notout", 32'(notout), ~m_reg & MASK);
      check("serialOutput", 32'(serialOutput), m_so);
      check("busy", 32'(busy), 32'(m_left > 0));
      check("done", 32'(done), 32'(m_done));
      if (busy) busy_n++;
      if (done) done_n++;
   endtask

   task automatic load(input logic [W-1:0] v);
      enablePreset = 1'b1; preset = v;
      tick();
      enablePreset = 1'b0;
   endtask

   task automatic go(input logic [1:0] m, input logic [CW-1:0] n);
      mode = m; shiftCount = n; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      // Reset
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("rst_out", 32'(out), 0);
      check("rst_notout", 32'(notout), 32'h3f);

      // Shift right by 2 with MSB input 1
      load(6'b101101);
      busy_n = 0; done_n = 0;
      serialInputMsb = 1'b1;
      go(2'b00, 3'd2);
      repeat (3) tick();
      check("shr_busy_cycles", busy_n, 2);
      check("shr_done_pulses", done_n, 1);
      check("shr_out", 32'(out), 32'b111011);
      check("shr_so", 32'(serialOutput), 0);

      // Rotate left by 3
      load(6'b100110);
      busy_n = 0; done_n = 0;
      go(2'b11, 3'd3);
      repeat (4) tick();
      check("rol_out", 32'(out), 32'b110100);
      check("rol_notout", 32'(notout), 32'b001011);
      check("rol_done_pulses", done_n, 1);

      // Preset aborts a left-shift burst
      load(6'b000001);
      serialInputLsb = 1'b0;
      busy_n = 0; done_n = 0;
      go(2'b01, 3'd5);
      repeat (2) tick();
      load(6'b010101);
      check("abort_out", 32'(out), 32'b010101);
      check("abort_busy", 32'(busy), 0);
      repeat (5) tick();
      check("abort_no_done", done_n, 0);

      // Zero-length burst
      load(6'b101010);
      busy_n = 0; done_n = 0;
      go(2'b00, 3'd0);
      check("n0_done", 32'(done), 1);
      tick();
      check("n0_busy_never", busy_n, 0);
      check("n0_out", 32'(out), 32'b101010);

      // start while busy is ignored
      busy_n = 0; done_n = 0;
      go(2'b10, 3'd3);
      go(2'b01, 3'd7);
      repeat (4) tick();
      check("restart_busy_cycles", busy_n, 3);
      check("restart_done_pulses", done_n, 1);

      // clear mid-burst, then a fresh burst
      load(6'b110011);
      busy_n = 0; done_n = 0;
      go(2'b10, 3'd7);
      repeat (3) tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("clr_out", 32'(out), 0);
      check("clr_busy", 32'(busy), 0);
      repeat (6) tick();
      check("clr_no_done", done_n, 0);
      load(6'b000111);
      busy_n = 0; done_n = 0;
      go(2'b01, 3'd2);
      repeat (3) tick();
      check("post_clr_busy", busy_n, 2);
      check("post_clr_done", done_n, 1);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         clear          = ($urandom % 50) == 0;
         enablePreset   = ($urandom % 15) == 0;
         start          = ($urandom % 3) == 0;
         mode           = 2'($urandom);
         shiftCount     = CW'($urandom);
         preset         = W'($urandom);
         serialInputMsb = 1'($urandom);
         serialInputLsb = 1'($urandom);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
